// File: rtl/dmem_responder.sv
// Single-port word memory answering one load/store at a time after a fixed
// LATENCY, with misalignment / range / conflicting-op error reporting.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] Address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_nstate;
  logic [3:0]  r_cnt, w_ncnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_rd, r_wr, r_ready, r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_req, w_accept, w_resp_next, w_src_rd, w_src_wr, w_err, w_we;
  logic [31:0] w_src_addr;
  logic [29:0] w_idx;

  assign w_req       = memRead | memWrite;
  assign w_accept    = (r_state == IDLE) && w_req;
  assign w_resp_next = (w_nstate == RESP);

  // With LATENCY=1 the access entering RESP is still on the inputs, not latched
  assign w_src_addr = (r_state == IDLE) ? Address  : r_addr;
  assign w_src_rd   = (r_state == IDLE) ? memRead  : r_rd;
  assign w_src_wr   = (r_state == IDLE) ? memWrite : r_wr;
  assign w_idx      = w_src_addr[31:2];
  assign w_err      = (w_src_addr[1:0] != 2'b00) || (w_idx >= 30'(DEPTH)) ||
                      (w_src_rd && w_src_wr);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        if (LATENCY == 1) w_nstate = RESP;
        else begin
          w_nstate = WAIT;
          w_ncnt   = CNT_LD;
        end
      end
      WAIT: if (r_cnt == 4'd0) w_nstate = RESP;
            else               w_ncnt   = r_cnt - 4'd1;
      RESP: w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_ready <= w_resp_next;
      r_err   <= w_resp_next && w_err;
      if (w_resp_next) begin
        if (w_err)         r_rdata <= 32'd0;
        else if (w_src_rd) r_rdata <= r_mem[w_src_addr[AW+1:2]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_addr  <= Address;
      r_wdata <= writeData;
      r_rd    <= memRead;
      r_wr    <= memWrite;
    end
  end

  // Store commits on the edge closing RESP; r_err already covers both-ops case
  assign w_we = (r_state == RESP) && r_wr && !r_err && !rst;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr[AW+1:2]] <= r_wdata;
  end

  assign readData = r_rdata;
  assign ready    = r_ready;
  assign err      = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) each run directed
// accesses against an event-scheduled reference model plus literal checks.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 2 : 1;

    logic        rst = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] Address = 32'd0, writeData = 32'd0;
    logic [31:0] readData;
    logic        ready, err;

    dmem_responder #(.DEPTH(1024), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
      .Address(Address), .writeData(writeData),
      .readData(readData), .ready(ready), .err(err)
    );

    // Reference: one outstanding access, answered in cycle accept+L, store
    // applied when that response cycle ends.
    logic [31:0] m [int];
    int          c = 0, due = -1;
    logic        p_rd = 1'b0, p_wr = 1'b0, p_err = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wd = 32'd0;
    logic [31:0] e_data = 32'd0;
    logic        e_rdy = 1'b0, e_err = 1'b0;
    bit          armed = 1'b0;

    initial forever begin
      @(posedge clk);
      if (rst) begin
        due = -1; e_rdy = 1'b0; e_err = 1'b0; e_data = 32'd0; armed = 1'b1;
      end else begin
        if (due == c) begin
          if (p_wr && !p_err) m[int'(p_addr[31:2])] = p_wd;
          due = -1;
        end else if (due < 0 && (memRead || memWrite)) begin
          p_rd = memRead; p_wr = memWrite; p_addr = Address; p_wd = writeData;
          p_err = (Address[1:0] != 2'b00) || (Address[31:2] >= 30'd1024) ||
                  (memRead && memWrite);
          due = c + L;
        end
        if (due == c + 1) begin
          e_rdy = 1'b1; e_err = p_err;
          if (p_err) e_data = 32'd0;
          else if (p_rd) e_data = m.exists(int'(p_addr[31:2])) ? m[int'(p_addr[31:2])] : 32'hxxxxxxxx;
        end else begin
          e_rdy = 1'b0; e_err = 1'b0;
        end
      end
      c++;
    end

    initial forever begin
      @(negedge clk);
      if (armed) begin
        chk($sformatf("L%0d c%0d ready", L, c), 32'(ready), 32'(e_rdy));
        chk($sformatf("L%0d c%0d err", L, c), 32'(err), 32'(e_err));
        chk($sformatf("L%0d c%0d readData", L, c), readData, e_data);
      end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] d, output logic e);
      @(negedge clk);
      memRead = rd; memWrite = wr; Address = a; writeData = wd;
      lat = -1; d = 32'd0; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (ready) begin
          lat = k; d = readData; e = err;
          break;
        end
      end
      memRead = 1'b0; memWrite = 1'b0;
      if (lat < 0) chk($sformatf("L%0d ready timeout", L), 32'd0, 32'd1);
    endtask

    initial begin
      int lat, first, second, seen;
      logic [31:0] d;
      logic e;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk($sformatf("L%0d reset readData", L), readData, 32'd0);
      chk($sformatf("L%0d reset ready", L), 32'(ready), 32'd0);

      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, d, e);
      chk($sformatf("L%0d wr latency", L), 32'(lat), 32'(L));
      chk($sformatf("L%0d wr err", L), 32'(e), 32'd0);
      access(1'b1, 1'b0, 32'h10, 32'd0, lat, d, e);
      chk($sformatf("L%0d rd latency", L), 32'(lat), 32'(L));
      chk($sformatf("L%0d rd data", L), d, 32'hDEADBEEF);
      chk($sformatf("L%0d rd err", L), 32'(e), 32'd0);

      access(1'b1, 1'b0, 32'h12, 32'd0, lat, d, e);
      chk($sformatf("L%0d misaligned err", L), 32'(e), 32'd1);
      chk($sformatf("L%0d misaligned data", L), d, 32'd0);
      chk($sformatf("L%0d misaligned latency", L), 32'(lat), 32'(L));
      access(1'b0, 1'b1, 32'h1000, 32'h55, lat, d, e);
      chk($sformatf("L%0d range err", L), 32'(e), 32'd1);
      access(1'b1, 1'b1, 32'h10, 32'h77, lat, d, e);
      chk($sformatf("L%0d both-op err", L), 32'(e), 32'd1);
      access(1'b1, 1'b0, 32'h10, 32'd0, lat, d, e);
      chk($sformatf("L%0d data after errors", L), d, 32'hDEADBEEF);

      // Held read: second acceptance only once the first response is done
      @(negedge clk);
      memRead = 1'b1; Address = 32'h10;
      first = -1; second = -1;
      for (int k = 1; k <= 2 * L + 1; k++) begin
        @(negedge clk);
        if (ready) begin
          if (first < 0) first = k;
          else if (second < 0) second = k;
        end
      end
      memRead = 1'b0;
      chk($sformatf("L%0d held first ready", L), 32'(first), 32'(L));
      chk($sformatf("L%0d held second ready", L), 32'(second), 32'(2 * L + 1));
      repeat (L + 2) @(negedge clk);

      // Reset while a store is pending, with a store also offered during reset
      access(1'b0, 1'b1, 32'h20, 32'h1, lat, d, e);
      @(negedge clk);
      memWrite = 1'b1; Address = 32'h20; writeData = 32'h2;
      @(negedge clk);
      rst = 1'b1; writeData = 32'h3;
      @(negedge clk);
      chk($sformatf("L%0d rst ready", L), 32'(ready), 32'd0);
      chk($sformatf("L%0d rst err", L), 32'(err), 32'd0);
      chk($sformatf("L%0d rst readData", L), readData, 32'd0);
      rst = 1'b0; memWrite = 1'b0;
      seen = 0;
      repeat (L + 2) begin
        @(negedge clk);
        if (ready) seen++;
      end
      chk($sformatf("L%0d request during rst ignored", L), 32'(seen), 32'd0);
      access(1'b1, 1'b0, 32'h20, 32'd0, lat, d, e);
      chk($sformatf("L%0d data after rst", L), d, 32'h1);
      chk($sformatf("L%0d err after rst", L), 32'(e), 32'd0);
      repeat (2) @(negedge clk);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 5000 && n_done < 2; i++) @(posedge clk);
    if (n_done < 2) chk("sequence completion", 32'(n_done), 32'd2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
